pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised pipeline-register chain for the VLIW datapath: it replaces the fixed-width, enable-only inter-stage latches with a generic DEPTH-stage, WIDTH-bit chain. The chain carries a per-stage valid bit and a valid/ready handshake, so bubbles collapse automatically. It also supports a global stall, a synchronous flush (branch/jump kill), and an optional occupancy counter. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB, with control and data fields concatenated into in_data.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 1, number of register stages (≥1; 0 is illegal, elaboration error)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- stall  input  1  global hold; freezes every stage
- flush  input  1  synchronous kill of all in-flight entries
- in_valid  input  1  upstream entry present
- in_ready  output  1  chain accepts an entry this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage DEPTH-1 holds a valid entry
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  payload of stage DEPTH-1
- occupancy  output  $clog2(DEPTH+1)  count of valid stages (see Configuration)

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): v[i] (1 bit) and d[i] (WIDTH bits).
- Advance terms, combinational:
  - adv[DEPTH] = out_ready & ~stall
  - adv[i] = ~stall & (~v[i] | adv[i+1])
- Bubble collapse: an empty stage loads even if downstream is blocked.
- in_ready = adv[0].
- out_valid = v[DEPTH-1] & ~stall.
- out_data = d[DEPTH-1] (not masked).
- On a clock edge, for each stage with adv[i]=1:
  - v[i] <= src_v.
  - d[i] <= src_d only if src_v=1; otherwise d[i] holds (no toggling on bubbles).
  - src is in_valid/in_data for i=0, and v[i-1]/d[i-1] otherwise.
- Stages with adv[i]=0 hold v and d.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- flush=1 (priority over all else except reset):
  - All v[i] <= 0 at the edge.
  - d unchanged.
  - Any input or output transfer in that cycle is discarded; the upstream must treat it as killed.
- stall=1 with flush=1: flush wins.
- Reset (reset=0, async): all v and d cleared to 0 immediately, independent of clk.
- Reset values: out_valid=0, out_data=0, occupancy=0, in_ready=1 once reset deasserts and stall=0.

## Timing
- Latency: an entry accepted at edge N appears at out_valid after edge N+DEPTH-1 (DEPTH=1: visible the cycle after acceptance).
- Throughput: 1 entry/cycle sustained with out_ready=1.
- Capacity: DEPTH entries.
- Full: all v=1 and out_ready=0 → in_ready=0.
- Full with out_ready=1: in_ready=1; simultaneous accept and emit, occupancy unchanged.
- Combinational paths:
  - out_ready → in_ready, through DEPTH stages (ripple; the integrator budgets it).
  - stall → in_ready / out_valid.
  - No path from in_valid to in_ready.
- Reset deassertion must be synchronised externally to clk.

## Configuration
- Macro: PIPE_OCC_COUNT_EN.
- With the macro defined:
  - occupancy is a registered counter.
  - Each edge: next = occupancy + in_xfer − out_xfer.
  - flush forces 0; reset forces 0.
  - It always equals the popcount of v.
- Without the macro: occupancy is tied to constant 0 and no counter logic is synthesised. The port stays present.

## Test plan
- Reset/idle: reset=0 mid-stream with DEPTH=3 and 2 entries in flight → out_valid=0, out_data=0 and occupancy=0 immediately, without a clock edge; after release, in_ready=1.
- Streaming: WIDTH=32, DEPTH=3, out_ready=1, in_data 0x1..0x8 back-to-back → out_data 0x1..0x8 consecutive, first one after the 3rd edge, no gaps.
- Backpressure/collapse: DEPTH=3, out_ready=0, push 0xA, 0xB, 0xC → in_ready=0 after the 3rd accept, occupancy=3; out_ready=1 for one cycle → 0xA emitted, in_ready=1 in the same cycle.
- Bubble collapse: DEPTH=4, one entry 0x55 then idle, out_ready=0 → the entry settles in stage 3 and in_ready stays 1 until 4 entries are held.
- Flush: DEPTH=3, 3 valid entries, flush=1 with in_valid=1, in_data=0x99 → next cycle out_valid=0, occupancy=0, and 0x99 is never emitted.
- Stall: stall=1 for 2 cycles with entries present → in_ready=0, out_valid=0, contents unchanged; after release, the original order resumes. With flush=1 during stall → the chain empties.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised valid/ready pipeline register chain
//
// Purpose: DEPTH-stage, WIDTH-bit inter-stage register chain with per-stage
// valid bits, bubble collapse, global stall, synchronous flush and an
// optional occupancy counter (enabled by defining PIPE_OCC_COUNT_EN).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (clears all valid and data)
//   stall      global hold, freezes every stage
//   flush      synchronous kill of all in-flight entries
//   in_valid   upstream entry present
//   in_ready   chain accepts an entry this cycle
//   in_data    upstream payload
//   out_valid  output stage holds a valid entry (masked by stall)
//   out_ready  downstream accepts this cycle
//   out_data   payload of the output stage (not masked)
//   occupancy  number of valid stages (constant 0 without PIPE_OCC_COUNT_EN)

`timescale 1ns/1ps

module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  if (DEPTH < 1) begin : g_depth_check
    $error("pipe_stage_chain: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_src_v;
  logic [WIDTH-1:0] w_src_d [DEPTH];

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    // Stage gi may advance when any stage from gi to the output is empty,
    // or the output drains. This is the unrolled form of
    // adv[i] = ~stall & (~v[i] | adv[i+1]); the logical ripple from
    // out_ready is still there, just flattened into a wide AND.
    assign w_adv[gi] = ~stall & (out_ready | ~(&r_v[DEPTH-1:gi]));

    if (gi == 0) begin : g_head
      assign w_src_v[gi] = in_valid;
      assign w_src_d[gi] = in_data;
    end else begin : g_link
      assign w_src_v[gi] = r_v[gi-1];
      assign w_src_d[gi] = r_d[gi-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          r_v[i] <= 1'b0;
        end else if (w_adv[i]) begin
          r_v[i] <= w_src_v[i];
        end
        // Payload only loads with a valid source so bubbles do not toggle
        // the data registers; flush leaves data untouched.
        if (!flush && w_adv[i] && w_src_v[i]) begin
          r_d[i] <= w_src_d[i];
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[DEPTH-1] & ~stall;
  assign out_data  = r_d[DEPTH-1];

`ifdef PIPE_OCC_COUNT_EN
  logic [OCC_W-1:0] r_occ;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
    end
  end

  assign occupancy = r_occ;
`else
  assign occupancy = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - self-checking bench for pipe_stage_chain

`timescale 1ns/1ps

module tb_pipe_stage_chain;

  localparam int D = 3;

  logic        clk;
  logic        reset;
  logic        stall, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [2:0]  b_occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit cmp_en   = 0;

  // Reference model: ordered list of entries (oldest first) with the stage
  // index each one currently sits in, plus the last payload that reached the
  // output stage.
  logic [31:0] mq_d[$];
  int          mq_p[$];
  logic [31:0] m_last  = '0;
  int          m_emits = 0;

  logic [31:0] emit_log[$];
  int          emit_cyc[$];

  pipe_stage_chain #(.WIDTH(32), .DEPTH(D)) u_dut3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_chain #(.WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int exp_occ(input int n);
`ifdef PIPE_OCC_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  function automatic logic m_in_ready();
    return !stall && (mq_d.size() < D || out_ready);
  endfunction

  function automatic logic m_out_valid();
    return !stall && mq_d.size() > 0 && mq_p[0] == D - 1;
  endfunction

  task automatic m_step();
    logic [31:0] nd[$];
    int          np_q[$];
    int          lim;
    int          np;
    if (flush) begin
      mq_d.delete();
      mq_p.delete();
      return;
    end
    if (stall) return;
    lim = D - 1;
    for (int k = 0; k < mq_d.size(); k++) begin
      if (k == 0 && mq_p[0] == D - 1 && out_ready) begin
        m_emits++;
        continue;
      end
      np = (mq_p[k] + 1 < lim) ? mq_p[k] + 1 : lim;
      if (np == D - 1 && mq_p[k] != D - 1) m_last = mq_d[k];
      nd.push_back(mq_d[k]);
      np_q.push_back(np);
      lim = np - 1;
    end
    if (in_valid && lim >= 0) begin
      if (D == 1) m_last = in_data;
      nd.push_back(in_data);
      np_q.push_back(0);
    end
    mq_d = nd;
    mq_p = np_q;
  endtask

  always @(posedge clk) begin
    if (reset) m_step();
  end

  always @(negedge clk) begin
    if (cmp_en && reset) begin
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, m_out_valid());
      chk("out_data", out_data, m_last);
      chk("occupancy", occupancy, exp_occ(mq_d.size()));
      if (out_valid && out_ready && !flush) begin
        emit_log.push_back(out_data);
        emit_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic st, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  task automatic drive_b(input logic iv, input logic [31:0] id);
    @(posedge clk);
    #1;
    b_in_valid = iv;
    b_in_data  = id;
  endtask

  task automatic drain();
    repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // streaming 1..8 with out_ready=1
    emit_log.delete(); emit_cyc.delete();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 32'(k), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (k == 3) chk("stream_not_yet_valid", out_valid, 0);
      if (k == 4) begin
        chk("stream_first_valid", out_valid, 1);
        chk("stream_first_data", out_data, 1);
      end
    end
    drain();
    chk("stream_count", emit_log.size(), 8);
    if (emit_log.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("stream_data", emit_log[k], k + 1);
      chk("stream_no_gaps", emit_cyc[7] - emit_cyc[0], 7);
    end

    // backpressure and collapse
    emit_log.delete();
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_occ", occupancy, exp_occ(3));
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_emit_valid", out_valid, 1);
    chk("bp_emit_data", out_data, 32'hA);
    chk("bp_emit_in_ready", in_ready, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("bp_order_count", emit_log.size(), 3);
    if (emit_log.size() == 3) begin
      chk("bp_order_0", emit_log[0], 32'hA);
      chk("bp_order_2", emit_log[2], 32'hC);
    end

    // flush with a concurrent input
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    emit_log.delete();
    drive(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_occ", occupancy, 0);
    drain();
    chk("flush_nothing_emitted", emit_log.size(), 0);

    // stall holds contents, then order resumes
    drive(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
    emit_log.delete();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 0);
    end
    drain();
    chk("stall_resume_count", emit_log.size(), 2);
    if (emit_log.size() == 2) begin
      chk("stall_resume_0", emit_log[0], 32'h41);
      chk("stall_resume_1", emit_log[1], 32'h42);
    end

    // flush during stall empties the chain
    drive(1'b1, 32'h61, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h62, 1'b0, 1'b0, 1'b0);
    emit_log.delete();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_flush_occ", occupancy, 0);
    drain();
    chk("stall_flush_empty", emit_log.size(), 0);

    // asynchronous reset mid-stream
    drive(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h5B, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_reset_data", out_data, 32'h5A);
    #1;
    reset = 1'b0;
    mq_d.delete(); mq_p.delete(); m_last = '0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_occ", occupancy, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);

    // bubble collapse on the DEPTH=4 instance
    drive_b(1'b1, 32'h55);
    for (int k = 0; k < 4; k++) begin
      drive_b(1'b0, 32'h0);
      @(negedge clk);
      chk("bub_in_ready_idle", b_in_ready, 1);
      if (k == 3) begin
        chk("bub_settled_valid", b_out_valid, 1);
        chk("bub_settled_data", b_out_data, 32'h55);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive_b(1'b1, 32'h56 + 32'(k));
      @(negedge clk);
      chk("bub_in_ready_filling", b_in_ready, 1);
    end
    drive_b(1'b0, 32'h0);
    @(negedge clk);
    chk("bub_full_in_ready", b_in_ready, 0);
    chk("bub_full_occ", b_occupancy, exp_occ(4));
    chk("bub_full_data", b_out_data, 32'h55);

    // randomized traffic against the model
    drain();
    emit_log.delete();
    m_emits = 0;
    for (int k = 0; k < 2000; k++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
            ($urandom % 10) == 0, ($urandom % 25) == 0);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rand_emit_count", emit_log.size(), m_emits);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
